player_hit_detector: RTL and testbench
======================================

Name: player_hit_detector

Overview:
- Produces the playerHit pulse consumed by the player bitmap's blink logic, together with the lives count and game-over flag.
- Watches per-pixel drawing requests from the player, alien shots and the alien fleet, and latches collisions over one video frame.
- Resolves latched collisions once per frame at startOfFrame.
- Enforces a post-hit grace window and sits between the object drawers and the game-control logic.

Parameters:
- INIT_LIVES, 3, lives loaded at reset and on each new game (1..7).
- GRACE_FRAMES, 120, frames after a hit during which shot collisions are ignored (1..255).

Ports:
- clk  input  1  system clock
- resetN  input  1  asynchronous active-low reset
- startOfFrame  input  1  one-cycle pulse at frame start
- playGame  input  1  high while a game is running; low clears the block to IDLE
- playerDrawingRequest  input  1  player pixel active at current pixel
- alienShotDrawingRequest  input  1  any alien shot pixel active
- alienDrawingRequest  input  1  any alien body pixel active
- playerHit  output  1  one-cycle pulse: player lost a life
- shotClear  output  1  one-cycle pulse, coincident with playerHit: alien shots must despawn
- livesLeft  output  3  remaining lives
- inGrace  output  1  high during grace window
- gameOver  output  1  sticky game-over flag

Behaviour:
- Clock and reset: one clock, clk. Reset resetN is asynchronous, active-low.
- Reset values: playerHit=0, shotClear=0, livesLeft=INIT_LIVES, inGrace=0, gameOver=0. State=IDLE, shot and invasion flags=0, grace counter=0.
- States: IDLE, ACTIVE, GRACE, OVER.
- playGame low:
  - Checked synchronously every cycle; it overrides all other events.
  - Next state is IDLE. Flags and counter clear, livesLeft reloads to INIT_LIVES, gameOver clears, pulses forced to 0.
- IDLE -> ACTIVE on the first cycle with playGame high. Flags start cleared.
- Collision latching (ACTIVE and GRACE only, on cycles other than startOfFrame):
  - shotFlag sets when playerDrawingRequest & alienShotDrawingRequest.
  - invFlag sets when playerDrawingRequest & alienDrawingRequest.
  - Both flags are sticky until resolved.
  - A collision in the startOfFrame cycle itself is latched into the new frame's flags, after they are cleared.
- Resolution on startOfFrame. All outputs are registered, so effects appear the cycle after the startOfFrame pulse.
  - ACTIVE, invFlag=1: go to OVER, gameOver=1. livesLeft unchanged, no playerHit.
  - ACTIVE, shotFlag=1, invFlag=0:
    - playerHit and shotClear pulse high for exactly 1 cycle, and livesLeft decrements by 1.
    - If livesLeft was 1: it becomes 0, state goes to OVER, gameOver=1.
    - Otherwise: state goes to GRACE, grace counter loads GRACE_FRAMES.
  - GRACE:
    - shotFlag is discarded with no pulse.
    - invFlag=1 still goes to OVER.
    - Otherwise the counter decrements. When it reads 1 at a startOfFrame, go to ACTIVE (grace lasts exactly GRACE_FRAMES frames).
  - Both flags clear at every startOfFrame, whether or not they were acted on.
- inGrace = (state==GRACE).
- OVER:
  - Sticky; all collision inputs are ignored and no pulses are produced.
  - Leaves only via playGame low or reset.
- Width rules:
  - livesLeft never underflows below 0.
  - Grace counter is 8 bits and never wraps.
- Simultaneous events: invasion beats shot in the same frame. playGame low beats startOfFrame.
- Reset mid-operation: returns immediately to the reset values; any pulse in flight is dropped.

Test Plan:
- Reset, playGame=1, frame with player&shot overlap for 3 cycles, then startOfFrame -> exactly one playerHit/shotClear pulse the cycle after startOfFrame; livesLeft 3->2; inGrace=1.
- Same as above, then a shot overlap in each of the next 119 frames -> no pulses, livesLeft stays 2. inGrace falls after the 120th startOfFrame; an overlap in frame 121 -> playerHit, livesLeft=1.
- Three spaced hits, each after grace expires -> livesLeft 3->2->1->0; the third hit pulses playerHit and sets gameOver=1; later overlaps produce nothing.
- Shot and alien overlap with the player in the same frame -> gameOver=1, no playerHit, livesLeft unchanged (3).
- In OVER, drop playGame for 1 cycle, then raise it -> gameOver=0, livesLeft=3, state ACTIVE.
- Overlap only in the startOfFrame cycle -> no pulse at that frame boundary; pulse after the next startOfFrame. Assert resetN low mid-grace -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/player_hit_detector_if.sv
// Signal bundle between the object drawers / game control and the player hit detector.
interface player_hit_detector_if;
    logic       startOfFrame;
    logic       playGame;
    logic       playerDrawingRequest;
    logic       alienShotDrawingRequest;
    logic       alienDrawingRequest;
    logic       playerHit;
    logic       shotClear;
    logic [2:0] livesLeft;
    logic       inGrace;
    logic       gameOver;

    modport master (
        output startOfFrame, playGame, playerDrawingRequest,
               alienShotDrawingRequest, alienDrawingRequest,
        input  playerHit, shotClear, livesLeft, inGrace, gameOver
    );

    modport slave (
        input  startOfFrame, playGame, playerDrawingRequest,
               alienShotDrawingRequest, alienDrawingRequest,
        output playerHit, shotClear, livesLeft, inGrace, gameOver
    );
endinterface

// File: rtl/player_hit_detector.sv
// Latches player collisions over a frame and resolves them at startOfFrame into
// hit pulses, a lives count, a post-hit grace window and a sticky game-over flag.
module player_hit_detector #(
    parameter int INIT_LIVES   = 3,
    parameter int GRACE_FRAMES = 120
) (
    input logic                  clk,
    input logic                  resetN,
    player_hit_detector_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, GRACE, OVER} state_t;

    localparam logic [2:0] LIVES0 = 3'(INIT_LIVES);
    localparam logic [7:0] GRACE0 = 8'(GRACE_FRAMES);

    state_t     state;
    logic       shot_flag, inv_flag;
    logic [7:0] grace_cnt;
    logic       hit_q, grace_q, over_q;
    logic [2:0] lives;
    logic       shot_now, inv_now;

    assign shot_now = bus.playerDrawingRequest & bus.alienShotDrawingRequest;
    assign inv_now  = bus.playerDrawingRequest & bus.alienDrawingRequest;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            shot_flag <= 1'b0;
            inv_flag  <= 1'b0;
            grace_cnt <= 8'd0;
            hit_q     <= 1'b0;
            grace_q   <= 1'b0;
            over_q    <= 1'b0;
            lives     <= LIVES0;
        end else if (!bus.playGame) begin
            state     <= IDLE;
            shot_flag <= 1'b0;
            inv_flag  <= 1'b0;
            grace_cnt <= 8'd0;
            hit_q     <= 1'b0;
            grace_q   <= 1'b0;
            over_q    <= 1'b0;
            lives     <= LIVES0;
        end else begin
            hit_q <= 1'b0;
            case (state)
                IDLE: begin
                    state     <= ACTIVE;
                    shot_flag <= 1'b0;
                    inv_flag  <= 1'b0;
                end
                ACTIVE, GRACE: begin
                    if (bus.startOfFrame) begin
                        // Old flags are resolved; this cycle's overlap seeds the new frame.
                        shot_flag <= shot_now;
                        inv_flag  <= inv_now;
                        if (inv_flag) begin
                            state     <= OVER;
                            over_q    <= 1'b1;
                            grace_q   <= 1'b0;
                            grace_cnt <= 8'd0;
                        end else if (state == GRACE) begin
                            if (grace_cnt <= 8'd1) begin
                                state     <= ACTIVE;
                                grace_q   <= 1'b0;
                                grace_cnt <= 8'd0;
                            end else begin
                                grace_cnt <= grace_cnt - 8'd1;
                            end
                        end else if (shot_flag && lives != 3'd0) begin
                            hit_q <= 1'b1;
                            lives <= lives - 3'd1;
                            if (lives == 3'd1) begin
                                state  <= OVER;
                                over_q <= 1'b1;
                            end else begin
                                state     <= GRACE;
                                grace_q   <= 1'b1;
                                grace_cnt <= GRACE0;
                            end
                        end
                    end else begin
                        shot_flag <= shot_flag | shot_now;
                        inv_flag  <= inv_flag | inv_now;
                    end
                end
                OVER: begin
                    shot_flag <= 1'b0;
                    inv_flag  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.playerHit = hit_q;
    assign bus.shotClear = hit_q;
    assign bus.livesLeft = lives;
    assign bus.inGrace   = grace_q;
    assign bus.gameOver  = over_q;
endmodule

// File: tb/tb_player_hit_detector.sv
// Directed test-plan sequence followed by random pixel traffic, every cycle
// compared against a frame-level model of lives, grace frames and game over.
module tb_player_hit_detector;
    localparam int INIT_LIVES   = 3;
    localparam int GRACE_FRAMES = 120;

    logic clk = 1'b0;
    logic resetN;
    int   errors = 0;
    int   checks = 0;
    int   dut_hits = 0;

    player_hit_detector_if bus ();

    player_hit_detector #(.INIT_LIVES(INIT_LIVES), .GRACE_FRAMES(GRACE_FRAMES)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: game-level view of the block
    bit m_started, m_over, m_shot, m_inv, m_hit;
    int m_lives, m_grace_left;

    task automatic model_clear();
        m_started = 0; m_over = 0; m_shot = 0; m_inv = 0; m_hit = 0;
        m_lives = INIT_LIVES; m_grace_left = 0;
    endtask

    task automatic model_step(input bit sof, input bit play, input bit p, input bit s, input bit a);
        m_hit = 0;
        if (!play) begin
            model_clear();
        end else if (!m_started) begin
            m_started = 1; m_shot = 0; m_inv = 0;
        end else if (m_over) begin
            m_shot = 0; m_inv = 0;
        end else if (sof) begin
            if (m_inv) begin
                m_over = 1; m_grace_left = 0;
            end else if (m_grace_left > 0) begin
                m_grace_left--;
            end else if (m_shot) begin
                m_hit = 1;
                m_lives--;
                if (m_lives == 0) m_over = 1;
                else m_grace_left = GRACE_FRAMES;
            end
            m_shot = p && s;
            m_inv  = p && a;
        end else begin
            m_shot = m_shot || (p && s);
            m_inv  = m_inv || (p && a);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("playerHit", 8'(bus.playerHit), 8'(m_hit));
        chk("shotClear", 8'(bus.shotClear), 8'(m_hit));
        chk("livesLeft", 8'(bus.livesLeft), 8'(m_lives));
        chk("inGrace",   8'(bus.inGrace),   8'(m_started && !m_over && m_grace_left > 0));
        chk("gameOver",  8'(bus.gameOver),  8'(m_over));
    endtask

    task automatic step(input bit sof, input bit play, input bit p, input bit s, input bit a);
        @(negedge clk);
        bus.startOfFrame = sof; bus.playGame = play;
        bus.playerDrawingRequest = p; bus.alienShotDrawingRequest = s; bus.alienDrawingRequest = a;
        @(posedge clk);
        model_step(sof, play, p, s, a);
        #1;
        if (bus.playerHit === 1'b1) dut_hits++;
        check_model();
    endtask

    // One 4-cycle frame: startOfFrame cycle, then three cycles of the given overlaps
    task automatic frame(input bit s, input bit a);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, s, a);
    endtask

    task automatic restart();
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        frame(0, 0);
    endtask

    initial begin
        bus.startOfFrame = 0; bus.playGame = 0; bus.playerDrawingRequest = 0;
        bus.alienShotDrawingRequest = 0; bus.alienDrawingRequest = 0;
        resetN = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        resetN = 1;

        // Single hit, lives 3->2, grace entered
        restart();
        frame(1, 0);
        step(1, 1, 0, 0, 0);
        chk("hit1_pulse", 8'(bus.playerHit), 8'd1);
        chk("hit1_lives", 8'(bus.livesLeft), 8'd2);
        chk("hit1_grace", 8'(bus.inGrace), 8'd1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        chk("hit1_count", 8'(dut_hits), 8'd1);

        // Shots ignored through the grace window, then a hit again
        for (int i = 0; i < 119; i++) frame(1, 0);
        chk("grace_held", 8'(bus.inGrace), 8'd1);
        chk("grace_lives", 8'(bus.livesLeft), 8'd2);
        chk("grace_nohit", 8'(dut_hits), 8'd1);
        frame(1, 0);
        chk("grace_end", 8'(bus.inGrace), 8'd0);
        step(1, 1, 0, 0, 0);
        chk("hit2_pulse", 8'(bus.playerHit), 8'd1);
        chk("hit2_lives", 8'(bus.livesLeft), 8'd1);

        // Three spaced hits down to zero lives
        restart();
        dut_hits = 0;
        for (int h = 0; h < 3; h++) begin
            frame(1, 0);
            for (int i = 0; i < GRACE_FRAMES; i++) frame(0, 0);
        end
        chk("three_hits", 8'(dut_hits), 8'd3);
        chk("zero_lives", 8'(bus.livesLeft), 8'd0);
        chk("over_set", 8'(bus.gameOver), 8'd1);
        for (int i = 0; i < 4; i++) frame(1, 1);
        chk("over_quiet", 8'(dut_hits), 8'd3);
        chk("over_lives", 8'(bus.livesLeft), 8'd0);

        // Invasion beats shot in the same frame
        restart();
        frame(1, 1);
        step(1, 1, 0, 0, 0);
        chk("inv_over", 8'(bus.gameOver), 8'd1);
        chk("inv_nohit", 8'(bus.playerHit), 8'd0);
        chk("inv_lives", 8'(bus.livesLeft), 8'd3);

        // Drop playGame for one cycle out of OVER
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("newgame_over", 8'(bus.gameOver), 8'd0);
        chk("newgame_lives", 8'(bus.livesLeft), 8'd3);

        // Overlap only in the startOfFrame cycle counts for the next boundary
        frame(0, 0);
        dut_hits = 0;
        step(1, 1, 1, 1, 0);
        chk("sof_ovl_nohit", 8'(bus.playerHit), 8'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("sof_ovl_hit", 8'(bus.playerHit), 8'd1);
        chk("sof_ovl_count", 8'(dut_hits), 8'd1);

        // Asynchronous reset in the middle of grace
        frame(0, 0);
        @(negedge clk);
        #2 resetN = 0;
        #1;
        model_clear();
        chk("rst_grace", 8'(bus.inGrace), 8'd0);
        chk("rst_lives", 8'(bus.livesLeft), 8'(INIT_LIVES));
        chk("rst_hit", 8'(bus.playerHit), 8'd0);
        chk("rst_over", 8'(bus.gameOver), 8'd0);
        @(negedge clk);
        resetN = 1;

        // Random traffic
        for (int c = 0; c < 6000; c++) begin
            step((c % 5) == 0, ($urandom_range(0, 999) >= 3),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
